mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands (rdA, rdB) for mult/multu/div/divu.
- Holds the architectural HI/LO registers read by mfhi/mflo and written by mthi/mtlo.
- Processes one operand bit per clock. A start/busy/done handshake lets control stall the pipeline until the result is ready.

## Interface
- N, 32, operand width; the cycle count of one operation equals N.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  request a new operation; sampled on posedge, honoured only in IDLE.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- inA  in  N  multiplicand / dividend (register rs).
- inB  in  N  multiplier / divisor (register rt).
- hi_wen  in  1  mthi: write wd into hi.
- lo_wen  in  1  mtlo: write wd into lo.
- wd  in  N  mthi/mtlo write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo hold the new result while it is high.
- div_by_zero  out  1  valid with done; set when div/divu had inB == 0.
- hi  out  N  HI register: upper product half or remainder.
- lo  out  N  LO register: lower product half or quotient.

## Operation
- States:
  - IDLE: on start, capture op, inA, inB and the operand signs into internal registers, then go to RUN.
  - RUN: stays exactly N cycles; bit counter runs N-1 down to 0. Move to FIX on the cycle the counter reaches 0.
  - FIX: write hi/lo, pulse done, return to IDLE.
- Operands are captured at the start edge. Changes on inA/inB/op after that edge have no effect.
- Signed ops (mult, div) operate on magnitudes; signs are applied in FIX.
  - Product: negate the 2N-bit result when the operand signs differ.
  - Quotient: negate when the signs differ.
  - Remainder: takes the sign of the dividend.
- Multiply: shift-add. Accumulator is 2N bits wide, product is modulo 2^(2N); hi = upper N bits, lo = lower N bits.
- Divide: restoring, one quotient bit per cycle; remainder register is N+1 bits.
- Divide by zero (inB == 0, div or divu):
  - Full latency is kept.
  - Result: lo = all ones, hi = captured inA, div_by_zero = 1 with done.
- Overflow case div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No flag.
- mthi/mtlo:
  - Honoured only in IDLE; ignored in RUN and FIX.
  - hi_wen and lo_wen may be asserted together.
  - If start and a write coincide in IDLE, the write is performed and is later overwritten by the result at FIX.
- start while busy is ignored; there is no queueing.
- div_by_zero is cleared on the next start.

## Timing
- Reset (asynchronous) forces state IDLE and counter = 0. All outputs go to 0: hi, lo, busy, done, div_by_zero.
- Reset mid-operation aborts the operation and produces no done pulse.
- Start accepted at edge E:
  - busy = 1 from E until edge E+N+1.
  - hi/lo are updated at edge E+N+1, and done = 1 for the cycle following E+N+1.
- Latency from start edge to valid result is N+1 cycles (33 for N=32).
- busy and done are never high together. busy = 1 exactly in RUN and FIX.
- start asserted during the done cycle is accepted (state is IDLE), which gives back-to-back throughput of one result per N+1 cycles.
- hi/lo are stable between operations; mthi/mtlo take effect at the next edge.

## Structure
- Shared package/header (constants.h) holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings: MD_IDLE, MD_RUN, MD_FIX;
  - MD_CYCLES = N.
- One combinational sub-module, md_step, is natural. It computes one shift-add step or one restore-subtract step from the accumulator, the operand register and op. The top module then holds only the FSM, the counter, the sign fix and HI/LO.

## Test plan
- mult, inA = 7, inB = 0xFFFFFFFD (-3) -> done at start+33: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. busy is high for exactly 33 cycles.
- multu, inA = inB = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- div and divu:
  - div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - divu 7 / 2 -> lo = 3, hi = 1.
  - div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- divu 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678, div_by_zero = 1 during done.
- Handshake and reset:
  - Second start at cycle 5 of an operation is ignored.
  - start asserted in the done cycle launches the next op; its done arrives 33 cycles later.
  - reset low at cycle 10 -> all outputs 0 immediately, no done.
- mthi with wd = 0xDEADBEEF in IDLE -> hi = 0xDEADBEEF next cycle. mtlo asserted during RUN -> lo unchanged.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mult_div_unit_pkg;

   localparam int MD_CYCLES = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/operand/result bundle between execute-stage control and the mult/div unit.
interface mult_div_unit_if #(parameter int N = 32) ();

   logic         start;
   logic [1:0]   op;
   logic [N-1:0] inA;
   logic [N-1:0] inB;
   logic         hi_wen;
   logic         lo_wen;
   logic [N-1:0] wd;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [N-1:0] hi;
   logic [N-1:0] lo;

   modport master (
      output start, op, inA, inB, hi_wen, lo_wen, wd,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, inA, inB, hi_wen, lo_wen, wd,
      output busy, done, div_by_zero, hi, lo
   );

endinterface

// File: rtl/mult_div_unit_md_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring divide step,
// both consuming operand bit [cnt] (MSB first).
module md_step #(
   parameter int N = 32
) (
   input  logic                 is_div,
   input  logic [$clog2(N)-1:0] cnt,
   input  logic [N-1:0]         a,
   input  logic [N-1:0]         b,
   input  logic [2*N-1:0]       acc,
   input  logic [N-1:0]         rem,
   output logic [2*N-1:0]       acc_nxt,
   output logic [N-1:0]         rem_nxt
);

   logic [2*N-1:0] acc_sh;
   logic [N:0]     rem_sh;
   logic [N:0]     diff;

   // The partial remainder is N+1 bits once the next dividend bit is shifted in;
   // a borrow out of that width means the trial subtraction must be restored.
   always_comb begin
      acc_sh  = acc << 1;
      rem_sh  = {rem, a[cnt]};
      diff    = rem_sh - {1'b0, b};
      acc_nxt = acc_sh;
      rem_nxt = rem;
      if (is_div) begin
         if (!diff[N]) begin
            rem_nxt    = diff[N-1:0];
            acc_nxt[0] = 1'b1;
         end else begin
            rem_nxt = rem_sh[N-1:0];
         end
      end else if (b[cnt]) begin
         acc_nxt = acc_sh + {{N{1'b0}}, a};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit mult/multu/div/divu unit holding HI/LO; one operand bit per clock,
// start/busy/done handshake, result written N+1 cycles after the start edge.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int N = MD_CYCLES
) (
   input  logic            clock,
   input  logic            reset,
   mult_div_unit_if.slave  bus
);

   localparam int CW = $clog2(N);

   md_state_e      state;
   logic [CW-1:0]  cnt;
   logic           is_div_r, sa, sb, dz;
   logic [N-1:0]   a_mag, b_mag, a_raw;
   logic [2*N-1:0] acc, acc_nxt;
   logic [N-1:0]   rem, rem_nxt;
   logic [N-1:0]   hi_r, lo_r;
   logic           busy_r, done_r, dbz_r;

   logic           st_signed, st_div, st_sa, st_sb;
   logic [2*N-1:0] prod;
   logic [N-1:0]   quo, rmd;

   assign st_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
   assign st_div    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
   assign st_sa     = st_signed & bus.inA[N-1];
   assign st_sb     = st_signed & bus.inB[N-1];

   md_step #(.N(N)) u_step (
      .is_div  (is_div_r),
      .cnt     (cnt),
      .a       (a_mag),
      .b       (b_mag),
      .acc     (acc),
      .rem     (rem),
      .acc_nxt (acc_nxt),
      .rem_nxt (rem_nxt)
   );

   // Signs are reapplied to the magnitude results; remainder follows the dividend.
   always_comb begin
      prod = (sa ^ sb) ? -acc : acc;
      quo  = (sa ^ sb) ? -acc[N-1:0] : acc[N-1:0];
      rmd  = sa ? -rem : rem;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         is_div_r <= 1'b0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         dz       <= 1'b0;
         a_mag    <= '0;
         b_mag    <= '0;
         a_raw    <= '0;
         acc      <= '0;
         rem      <= '0;
         hi_r     <= '0;
         lo_r     <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dbz_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (bus.hi_wen) hi_r <= bus.wd;
               if (bus.lo_wen) lo_r <= bus.wd;
               if (bus.start) begin
                  is_div_r <= st_div;
                  sa       <= st_sa;
                  sb       <= st_sb;
                  dz       <= st_div && (bus.inB == '0);
                  a_mag    <= st_sa ? -bus.inA : bus.inA;
                  b_mag    <= st_sb ? -bus.inB : bus.inB;
                  a_raw    <= bus.inA;
                  acc      <= '0;
                  rem      <= '0;
                  cnt      <= CW'(N - 1);
                  busy_r   <= 1'b1;
                  dbz_r    <= 1'b0;
                  state    <= MD_RUN;
               end
            end
            MD_RUN: begin
               acc <= acc_nxt;
               rem <= rem_nxt;
               if (cnt == '0) state <= MD_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            MD_FIX: begin
               if (!is_div_r) begin
                  {hi_r, lo_r} <= prod;
               end else if (dz) begin
                  hi_r <= a_raw;
                  lo_r <= '1;
               end else begin
                  hi_r <= rmd;
                  lo_r <= quo;
               end
               dbz_r  <= dz;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

endmodule
